// File: rtl/pe_elastic_reg_unit.sv
// Multi-channel PE register BEL. Each channel is a valid/ready elastic stage whose mode
// (bypass, pipeline register, FIFO, off) comes from its ConfigMem bits.
module pe_elastic_reg_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [2*NUM_CH-1:0]                     ConfigBits,
    input  logic [NUM_CH*DATA_WIDTH-1:0]            in_data,
    input  logic [NUM_CH-1:0]                       in_valid,
    output logic [NUM_CH-1:0]                       in_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]            out_data,
    output logic [NUM_CH-1:0]                       out_valid,
    input  logic [NUM_CH-1:0]                       out_ready,
    output logic [NUM_CH*$clog2(DEPTH+1)-1:0]       level
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_REG    = 2'b01,
        MODE_FIFO   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_e;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mode_e                 mode_q;
        logic [1:0]            cfg_c;
        logic                  flush, blocked, push, pop;
        logic                  ir, ov;
        logic [DATA_WIDTH-1:0] id, od_raw;
        logic [CW-1:0]         lvl;
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wr_ptr, rd_ptr;
        logic [CW-1:0]         count;
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] reg_q;

        assign cfg_c   = ConfigBits[2*c +: 2];
        assign id      = in_data[c*DATA_WIDTH +: DATA_WIDTH];
        // A config change flushes the channel for one cycle; the new mode applies next cycle.
        assign flush   = (cfg_c != mode_q);
        assign blocked = rst | flush;

        always_comb begin
            ir     = 1'b0;
            ov     = 1'b0;
            od_raw = '0;
            lvl    = '0;
            case (mode_q)
                MODE_BYPASS: begin
                    ir     = out_ready[c];
                    ov     = in_valid[c];
                    od_raw = id;
                end
                MODE_REG: begin
                    ir     = !valid_q || out_ready[c];
                    ov     = valid_q;
                    od_raw = reg_q;
                    lvl    = CW'(valid_q);
                end
                MODE_FIFO: begin
                    ir     = (count < DEPTH_C);
                    ov     = (count != '0);
                    od_raw = mem[rd_ptr];
                    lvl    = count;
                end
                default: ;
            endcase
            if (blocked) begin
                ir  = 1'b0;
                ov  = 1'b0;
                lvl = '0;
            end
        end

        assign push = in_valid[c] & ir;
        assign pop  = ov & out_ready[c];

        assign in_ready[c]                          = ir;
        assign out_valid[c]                         = ov;
        assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = ov ? od_raw : '0;
        assign level[c*CW +: CW]                    = lvl;

        always_ff @(posedge clk) begin
            mode_q <= mode_e'(cfg_c);
            if (rst || flush || mode_q == MODE_OFF) begin
                count   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                valid_q <= 1'b0;
                reg_q   <= '0;
            end else if (mode_q == MODE_REG) begin
                if (push) begin
                    reg_q   <= id;
                    valid_q <= 1'b1;
                end else if (pop) begin
                    valid_q <= 1'b0;
                end
            end else if (mode_q == MODE_FIFO) begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end

        // Stale FIFO contents are never visible: out_valid gates them, so mem needs no reset.
        always_ff @(posedge clk) begin
            if (mode_q == MODE_FIFO && push) mem[wr_ptr] <= id;
        end
    end
endmodule
